// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host-side transmitter and its line conditioning.
package ps2_host_tx_pkg;

    // Transmitter sequencing states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_RTS       = 3'd2,
        ST_SHIFT     = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5,
        ST_DONE      = 3'd6,
        ST_ERROR     = 3'd7
    } ps2_tx_state_e;

    // Commands and responses exchanged with the keyboard
    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] RESP_ACK     = 8'hFA;
    localparam logic [7:0] RELEASE      = 8'hF0;

    // Start + 8 data + parity + stop; the ACK slot is clocked as edge 11
    localparam int FRAME_LEN = 11;

    // Bits shifted out after the start bit, LSB first: data, odd parity, stop
    function automatic logic [9:0] build_frame(input logic [7:0] d);
        return {1'b1, ~^d, d};
    endfunction

endpackage

// File: rtl/ps2_host_tx_line_sync.sv
// Synchronises the raw PS/2 clock and data lines and flags ps2 clock falling edges.
module ps2_host_tx_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic Clock,
    input  logic nReset,
    input  logic clk_in,
    input  logic dat_in,
    output logic clk_s,
    output logic dat_s,
    output logic clk_fall
);

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
    logic                   clk_prev_q, clk_prev_d;

    // Shift the raw lines through the synchroniser chain
    always_comb begin
        clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], clk_in};
        dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], dat_in};
        clk_prev_d = clk_s;
    end

    // Lines idle high, so reset to 1 to avoid a false falling edge after reset
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            clk_prev_q <= clk_prev_d;
        end
    end

    assign clk_s    = clk_sync_q[SYNC_STAGES-1];
    assign dat_s    = dat_sync_q[SYNC_STAGES-1];
    assign clk_fall = clk_prev_q & ~clk_s;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, shift the
// frame on device clock falling edges, check the ACK, and report done or error.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | lines released, waiting for tx_start
// INHIBIT   | ps2 clock held low for INHIBIT_CYCLES
// RTS       | data pulled low (start bit) while clock still held low
// SHIFT     | clock released; falling edges 1..10 drive data, parity, stop
// ACK       | falling edge 11 samples the device ACK bit
// WAIT_IDLE | waiting for both lines high
// DONE      | tx_done pulse
// ERROR     | tx_error pulse (NACK or timeout), lines released
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       Clock,
    input  logic       nReset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;
    localparam logic [3:0]       LAST_SHIFT_EDGE = 4'(FRAME_LEN - 2);

    logic clk_s, dat_s, clk_fall;

    ps2_host_tx_line_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_line_sync (
        .Clock   (Clock),
        .nReset  (nReset),
        .clk_in  (ps2_clk_in),
        .dat_in  (ps2_dat_in),
        .clk_s   (clk_s),
        .dat_s   (dat_s),
        .clk_fall(clk_fall)
    );

    ps2_tx_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [9:0]       shift_q, shift_d;
    logic [3:0]       edge_q, edge_d;
    logic             clk_oe_q, clk_oe_d;
    logic             dat_oe_q, dat_oe_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;

    assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);

    // Next-state and registered-output decode
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        edge_d   = edge_q;
        clk_oe_d = clk_oe_q;
        dat_oe_d = dat_oe_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        error_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (tx_start) begin
                    state_d  = ST_INHIBIT;
                    clk_oe_d = 1'b1;
                    dat_oe_d = 1'b0;
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                    shift_d  = build_frame(tx_data);
                    edge_d   = '0;
                end
            end
            ST_INHIBIT: begin
                cnt_d = cnt_inc;
                if (cnt_q == INH_LAST) begin
                    state_d  = ST_RTS;
                    dat_oe_d = 1'b1;
                end
            end
            ST_RTS: begin
                state_d  = ST_SHIFT;
                clk_oe_d = 1'b0;
                cnt_d    = '0;
            end
            ST_SHIFT: begin
                cnt_d = cnt_inc;
                if (clk_fall) begin
                    dat_oe_d = ~shift_q[0];
                    shift_d  = {1'b0, shift_q[9:1]};
                    edge_d   = edge_q + 4'd1;
                    if (edge_q == LAST_SHIFT_EDGE) begin
                        state_d = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                cnt_d = cnt_inc;
                if (clk_fall) begin
                    if (dat_s) begin
                        state_d  = ST_ERROR;
                        error_d  = 1'b1;
                        clk_oe_d = 1'b0;
                        dat_oe_d = 1'b0;
                    end else begin
                        state_d = ST_WAIT_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                cnt_d = cnt_inc;
                if (clk_s && dat_s) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            ST_DONE, ST_ERROR: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d  = ST_IDLE;
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase

        // The device has TIMEOUT_CYCLES from clock release to finish the handshake
        if ((state_q inside {ST_SHIFT, ST_ACK, ST_WAIT_IDLE}) && (cnt_q >= TO_LAST)) begin
            state_d  = ST_ERROR;
            error_d  = 1'b1;
            done_d   = 1'b0;
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
        end
    end

    // State and output registers; reset releases both lines immediately
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            shift_q  <= '0;
            edge_q   <= '0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            edge_q   <= edge_d;
            clk_oe_q <= clk_oe_d;
            dat_oe_q <= dat_oe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;
    assign busy       = busy_q;
    assign tx_done    = done_q;
    assign tx_error   = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural keyboard clocks frames back, and the
// captured line bits are compared with the frame built from the byte value.
module tb_ps2_host_tx;

    localparam int INH = 20;
    localparam int TO  = 2000;

    logic       Clock = 1'b0;
    logic       nReset = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic       ps2_clk_in, ps2_dat_in;
    logic       ps2_clk_oe, ps2_dat_oe, busy, tx_done, tx_error;

    // Open-drain wired-AND of host and device
    assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
    assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO),
        .SYNC_STAGES   (2)
    ) dut (
        .Clock     (Clock),
        .nReset    (nReset),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .ps2_clk_in(ps2_clk_in),
        .ps2_dat_in(ps2_dat_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe),
        .busy      (busy),
        .tx_done   (tx_done),
        .tx_error  (tx_error)
    );

    always #5 Clock = ~Clock;

    int vectors = 0;
    int miscompares = 0;

    int   cyc = 0;
    int   t_clk_rise = 0, t_clk_fall = 0, t_rts = 0, t_done = 0, t_err = 0;
    int   done_cnt = 0, err_cnt = 0, both_cnt = 0;
    logic clk_oe_prev = 1'b0, dat_oe_prev = 1'b0;

    // Cycle-stamped event monitor, sampled just after each rising edge
    always @(posedge Clock) begin
        #1;
        cyc++;
        if (ps2_clk_oe && !clk_oe_prev) t_clk_rise = cyc;
        if (!ps2_clk_oe && clk_oe_prev) t_clk_fall = cyc;
        if (ps2_dat_oe && !dat_oe_prev && ps2_clk_oe) t_rts = cyc;
        if (tx_done) begin done_cnt++; t_done = cyc; end
        if (tx_error) begin err_cnt++; t_err = cyc; end
        if (tx_done && tx_error) both_cnt++;
        clk_oe_prev = ps2_clk_oe;
        dat_oe_prev = ps2_dat_oe;
    end

    // Reference: line bits after the start bit, LSB first, odd parity, stop
    function automatic logic [9:0] exp_frame(input logic [7:0] d);
        logic [9:0] f;
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            f[i] = ((int'(d) >> i) % 2) == 1;
            ones += (int'(d) >> i) % 2;
        end
        f[8] = (ones % 2) == 0;
        f[9] = 1'b1;
        return f;
    endfunction

    task automatic start_req(input logic [7:0] d);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge Clock);
        tx_start = 1'b0;
    endtask

    task automatic wait_not_busy(output bit ok);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(negedge Clock);
            n++;
        end
        ok = (busy === 1'b0);
    endtask

    // Keyboard model: waits for request-to-send, then generates 11 clocks,
    // reading data on rising edges 1..10 and optionally ACKing before edge 11
    task automatic dev_run(input bit do_ack, input int hp, output logic [9:0] seen,
                           output logic start_bit, output bit ok);
        int n;
        n = 0;
        ok = 1'b1;
        seen = '0;
        start_bit = 1'bx;
        while (!(ps2_clk_oe === 1'b0 && ps2_dat_oe === 1'b1)) begin
            @(negedge Clock);
            n++;
            if (n > 200) begin
                ok = 1'b0;
                return;
            end
        end
        start_bit = ps2_dat_in;
        repeat (hp) @(negedge Clock);
        for (int k = 1; k <= 11; k++) begin
            dev_clk = 1'b0;
            repeat (hp) @(negedge Clock);
            dev_clk = 1'b1;
            if (k <= 10) seen[k-1] = ps2_dat_in;
            if (k == 10 && do_ack) dev_dat = 1'b0;
            repeat (hp) @(negedge Clock);
            if (k == 11) dev_dat = 1'b1;
        end
    endtask

    task automatic test_reset();
        nReset = 1'b0;
        repeat (3) @(negedge Clock);
        vectors++;
        if ({ps2_clk_oe, ps2_dat_oe, busy, tx_done, tx_error} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_state: got %b want 00000", {ps2_clk_oe, ps2_dat_oe, busy, tx_done, tx_error});
        end
        nReset = 1'b1;
        repeat (3) @(negedge Clock);
        vectors++;
        if ({ps2_clk_oe, ps2_dat_oe, busy, tx_done, tx_error} !== 5'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: got %b want 00000", {ps2_clk_oe, ps2_dat_oe, busy, tx_done, tx_error});
        end
        start_req(8'($urandom));
        repeat (5) @(negedge Clock);
        vectors++;
        if ({ps2_clk_oe, busy} !== 2'b11) begin
            miscompares++;
            $display("FAIL inhibit_active: got clk_oe,busy=%b want 11", {ps2_clk_oe, busy});
        end
        #2 nReset = 1'b0;
        #1;
        vectors++;
        if ({ps2_clk_oe, ps2_dat_oe, busy} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_async: got clk_oe,dat_oe,busy=%b want 000", {ps2_clk_oe, ps2_dat_oe, busy});
        end
        @(negedge Clock);
        nReset = 1'b1;
        repeat (3) @(negedge Clock);
    endtask

    task automatic test_frame(input logic [7:0] d, input bit ack, input int hp, input bit chk_inh);
        logic [9:0] seen, exp;
        logic       sb;
        bit         ok;
        int         d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        exp = exp_frame(d);
        start_req(d);
        dev_run(ack, hp, seen, sb, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL rts_seen: data %h got no request-to-send within bound", d);
        end else begin
            vectors++;
            if (sb !== 1'b0) begin
                miscompares++;
                $display("FAIL start_bit: data %h got %b want 0", d, sb);
            end
            vectors++;
            if (seen !== exp) begin
                miscompares++;
                $display("FAIL frame_bits: data %h got %b want %b", d, seen, exp);
            end
            if (chk_inh) begin
                vectors++;
                if (t_rts - t_clk_rise !== INH) begin
                    miscompares++;
                    $display("FAIL inhibit_len: got %0d cycles want %0d", t_rts - t_clk_rise, INH);
                end
            end
        end
        wait_not_busy(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL busy_release: data %h busy still %b", d, busy);
        end
        vectors++;
        if ((done_cnt - d0) !== (ack ? 1 : 0) || (err_cnt - e0) !== (ack ? 0 : 1)) begin
            miscompares++;
            $display("FAIL outcome: data %h got done=%0d err=%0d want done=%0d err=%0d",
                     d, done_cnt - d0, err_cnt - e0, ack ? 1 : 0, ack ? 0 : 1);
        end
        vectors++;
        if ({ps2_clk_oe, ps2_dat_oe, busy} !== 3'b000) begin
            miscompares++;
            $display("FAIL lines_idle: got clk_oe,dat_oe,busy=%b want 000", {ps2_clk_oe, ps2_dat_oe, busy});
        end
        repeat (4) @(negedge Clock);
    endtask

    task automatic test_idle_rx();
        bit touched;
        touched = 1'b0;
        for (int i = 0; i < 40; i++) begin
            dev_clk = 1'($urandom);
            dev_dat = 1'($urandom);
            @(negedge Clock);
            if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0 || busy !== 1'b0) touched = 1'b1;
        end
        dev_clk = 1'b1;
        dev_dat = 1'b1;
        vectors++;
        if (touched) begin
            miscompares++;
            $display("FAIL idle_rx_untouched: got line drive or busy during device traffic, want none");
        end
        repeat (5) @(negedge Clock);
    endtask

    task automatic test_timeout();
        int d0, e0, n;
        d0 = done_cnt;
        e0 = err_cnt;
        start_req(8'($urandom));
        n = 0;
        while (!(ps2_clk_oe === 1'b0 && ps2_dat_oe === 1'b1) && n < 200) begin
            @(negedge Clock);
            n++;
        end
        vectors++;
        if (n >= 200) begin
            miscompares++;
            $display("FAIL timeout_rts: got no clock release within bound");
        end
        repeat (10) @(negedge Clock);
        start_req(8'hF4);
        n = 0;
        while (err_cnt == e0 && n < TO + 100) begin
            @(negedge Clock);
            n++;
        end
        vectors++;
        if (err_cnt == e0) begin
            miscompares++;
            $display("FAIL timeout_missing: got no tx_error within %0d cycles", TO + 100);
        end else begin
            vectors++;
            if (t_err - t_clk_fall !== TO) begin
                miscompares++;
                $display("FAIL timeout_len: got %0d cycles want %0d", t_err - t_clk_fall, TO);
            end
            vectors++;
            if ({ps2_clk_oe, ps2_dat_oe} !== 2'b00) begin
                miscompares++;
                $display("FAIL timeout_release: got clk_oe,dat_oe=%b want 00", {ps2_clk_oe, ps2_dat_oe});
            end
        end
        repeat (10) @(negedge Clock);
        vectors++;
        if ({ps2_clk_oe, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL start_not_queued: got clk_oe,busy=%b want 00", {ps2_clk_oe, busy});
        end
        vectors++;
        if ((done_cnt - d0) !== 0 || (err_cnt - e0) !== 1) begin
            miscompares++;
            $display("FAIL timeout_outcome: got done=%0d err=%0d want done=0 err=1", done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a, b;
        logic [9:0] s1, s2;
        logic       sb;
        bit         ok;
        int         n, d0, e0, hp;
        a  = 8'($urandom);
        b  = 8'($urandom);
        hp = int'($urandom_range(5, 10));
        d0 = done_cnt;
        e0 = err_cnt;
        tx_data  = a;
        tx_start = 1'b1;
        n = 0;
        while (ps2_clk_oe !== 1'b1 && n < 10) begin
            @(negedge Clock);
            n++;
        end
        tx_data = b;
        dev_run(1'b1, hp, s1, sb, ok);
        vectors++;
        if (!ok || s1 !== exp_frame(a)) begin
            miscompares++;
            $display("FAIL b2b_frame1: data %h got %b want %b", a, s1, exp_frame(a));
        end
        n = 0;
        while (done_cnt == d0 && n < 100) begin
            @(negedge Clock);
            n++;
        end
        n = 0;
        while (ps2_clk_oe !== 1'b1 && n < 20) begin
            @(negedge Clock);
            n++;
        end
        tx_start = 1'b0;
        vectors++;
        if (t_clk_rise - t_done !== 2) begin
            miscompares++;
            $display("FAIL b2b_restart_gap: got %0d cycles want 2", t_clk_rise - t_done);
        end
        dev_run(1'b1, hp, s2, sb, ok);
        vectors++;
        if (!ok || s2 !== exp_frame(b)) begin
            miscompares++;
            $display("FAIL b2b_frame2: data %h got %b want %b", b, s2, exp_frame(b));
        end
        wait_not_busy(ok);
        vectors++;
        if ((done_cnt - d0) !== 2 || (err_cnt - e0) !== 0) begin
            miscompares++;
            $display("FAIL b2b_outcome: got done=%0d err=%0d want done=2 err=0", done_cnt - d0, err_cnt - e0);
        end
    endtask

    initial begin
        test_reset();
        test_frame(8'hED, 1'b1, int'($urandom_range(5, 10)), 1'b0);
        test_frame(8'hF4, 1'b1, int'($urandom_range(5, 10)), 1'b1);
        test_idle_rx();
        for (int i = 0; i < 4; i++) begin
            test_frame(8'($urandom), 1'b1, int'($urandom_range(5, 10)), 1'b1);
        end
        test_frame(8'($urandom), 1'b0, int'($urandom_range(5, 10)), 1'b0);
        test_timeout();
        test_back_to_back();
        vectors++;
        if (both_cnt !== 0) begin
            miscompares++;
            $display("FAIL done_error_overlap: got %0d overlapping pulses want 0", both_cnt);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
